// File: rtl/zuart_tx_scheduler.sv
// zuart_tx_scheduler: round-robin arbiter feeding a single 8N1 UART transmitter
//   params : NUM_REQ (2..8 requesters), BPS_DIV (clocks per bit, >= 2)
//   clk, rst_n   : clock, asynchronous active-low reset
//   req, data    : per-requester request level and byte (byte i at data[8i+7:8i])
//   ack          : one-cycle pulse when requester i's byte is captured
//   busy         : a frame is in flight
//   grant_id     : index of the most recently granted requester
//   txd          : registered serial output, idle high
//   ZUART_SCHED_PARITY_EN : when defined, an even-parity bit is sent before the stop bit (8E1)
module zuart_tx_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int BPS_DIV = 434
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] data,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 busy,
  output logic [2:0]           grant_id,
  output logic                 txd
);
  localparam int CW = $clog2(BPS_DIV);
`ifdef ZUART_SCHED_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  logic par;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t           state;
  logic [CW-1:0]    cnt;
  logic [2:0]       bit_cnt, rr_ptr, gnt, off;
  logic [3:0]       sum;
  logic [7:0]       shreg, sel;
  logic [NUM_REQ-1:0] rot;
  logic             tick;
  // rotate requests so that bit 0 is the requester at rr_ptr; the lowest set bit wins
  assign rot = NUM_REQ'({req, req} >> rr_ptr);
  assign tick = cnt == CW'(BPS_DIV - 1);
  always_comb begin
    off = 3'd0;
    for (int k = NUM_REQ - 1; k >= 0; k--) off = rot[k] ? 3'(k) : off;
    sum = {1'b0, rr_ptr} + {1'b0, off};
    gnt = 3'(sum >= 4'(NUM_REQ) ? sum - 4'(NUM_REQ) : sum);
    sel = 8'd0;
    for (int k = 0; k < NUM_REQ; k++) sel = (gnt == 3'(k)) ? data[8*k +: 8] : sel;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      rr_ptr   <= '0;
      shreg    <= '0;
      ack      <= '0;
      busy     <= 1'b0;
      grant_id <= '0;
      txd      <= 1'b1;
`ifdef ZUART_SCHED_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      ack <= '0;
      // baud counter is held at zero in IDLE so each frame starts bit-aligned
      cnt <= (state == IDLE || tick) ? '0 : cnt + CW'(1);
      case (state)
        IDLE: if (|req) begin
          ack      <= NUM_REQ'(1) << gnt;
          shreg    <= sel;
          grant_id <= gnt;
          rr_ptr   <= gnt == 3'(NUM_REQ - 1) ? 3'd0 : gnt + 3'd1;
          busy     <= 1'b1;
          txd      <= 1'b0;
          state    <= START;
`ifdef ZUART_SCHED_PARITY_EN
          par      <= ^sel;
`endif
        end
        START: if (tick) begin
          txd     <= shreg[0];
          bit_cnt <= 3'd0;
          state   <= DATA;
        end
        DATA: if (tick) begin
          bit_cnt <= bit_cnt + 3'd1;
          shreg   <= shreg >> 1;
          if (bit_cnt == 3'd7) begin
`ifdef ZUART_SCHED_PARITY_EN
            txd   <= par;
            state <= PARITY;
`else
            txd   <= 1'b1;
            state <= STOP;
`endif
          end else txd <= shreg[1];
        end
`ifdef ZUART_SCHED_PARITY_EN
        PARITY: if (tick) begin
          txd   <= 1'b1;
          state <= STOP;
        end
`endif
        STOP: if (tick) begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_zuart_tx_scheduler.sv
// tb_zuart_tx_scheduler: directed bench with a frame-timeline reference model
module tb_zuart_tx_scheduler;
  localparam int N = 4;
  localparam int BPS = 8;
`ifdef ZUART_SCHED_PARITY_EN
  localparam int FLEN = 11 * BPS;
`else
  localparam int FLEN = 10 * BPS;
`endif
  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] data = '0;
  logic [N-1:0]   ack;
  logic           busy;
  logic [2:0]     grant_id;
  logic           txd;
  int total = 0;
  int bad = 0;
  int cyc = 0;

  zuart_tx_scheduler #(.NUM_REQ(N), .BPS_DIV(BPS)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .data(data),
    .ack(ack), .busy(busy), .grant_id(grant_id), .txd(txd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // reference model: a frame is a list of bits (start, data LSB first, [parity], stop),
  // each held BPS cycles; m_t is the cycle index inside the current frame, -1 when idle
  function automatic int pick(input logic [N-1:0] r, input int ptr);
    for (int k = 0; k < N; k++)
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    return 0;
  endfunction

  function automatic logic [7:0] byte_of(input int g);
    logic [8*N-1:0] t;
    t = data >> (8 * g);
    return t[7:0];
  endfunction

  function automatic logic [10:0] frame(input logic [7:0] b);
`ifdef ZUART_SCHED_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {2'b11, b, 1'b0};
`endif
  endfunction

  int           m_t = -1;
  int           m_ptr = 0;
  int           m_gid = 0;
  logic [10:0]  m_frame = '1;
  logic [N-1:0] m_ack = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t   <= -1;
      m_ptr <= 0;
      m_gid <= 0;
      m_ack <= '0;
    end else begin
      m_ack <= '0;
      if (m_t >= 0) m_t <= (m_t + 1 == FLEN) ? -1 : m_t + 1;
      else if (req != '0) begin
        m_gid   <= pick(req, m_ptr);
        m_ack   <= N'(1) << pick(req, m_ptr);
        m_ptr   <= (pick(req, m_ptr) + 1) % N;
        m_frame <= frame(byte_of(pick(req, m_ptr)));
        m_t     <= 0;
      end
    end
  end

  always @(negedge clk) begin
    check("txd", txd, (m_t < 0) ? 1'b1 : m_frame[m_t / BPS]);
    check("busy", busy, m_t >= 0);
    check("ack", ack, m_ack);
    check("grant_id", grant_id, m_gid);
  end

  task automatic wait_ack();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack == '0 && n < 300);
    check("ack_seen", |ack, 1'b1);
  endtask

  // called at a negedge: assert reset, confirm outputs drop immediately, release
  task automatic rst_pulse(input string name);
    #1 rst_n = 1'b0;
    #1;
    check({name, "_txd"}, txd, 1'b1);
    check({name, "_busy"}, busy, 1'b0);
    check({name, "_ack"}, ack, '0);
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  // single frame: hold req low after ack, sample mid-bit, return busy length
  task automatic frame_check(input string name, input logic [10:0] bits, input int len);
    int c;
    for (c = 0; busy && c < 200; c++) begin
      if (c % BPS == BPS / 2) check({name, "_bit"}, txd, bits[c / BPS]);
      if (c == 1) check({name, "_ack_width"}, ack, '0);
      @(negedge clk);
    end
    check({name, "_busy_len"}, c, len);
  endtask

  initial begin
    int prev;
    int seen;
    int n;
    @(negedge clk);
    check("rst_txd", txd, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_ack", ack, '0);
    check("rst_grant", grant_id, 3'd0);
    #1 rst_n = 1'b1;

    // single byte 0xA5 from requester 1
    @(negedge clk);
    data[15:8] = 8'hA5;
    req = 4'b0010;
    wait_ack();
    check("single_ack", ack, 4'b0010);
    check("single_gid", grant_id, 3'd1);
    req = '0;
`ifdef ZUART_SCHED_PARITY_EN
    frame_check("single", 11'b10101001010, 88);
`else
    frame_check("single", 11'b11101001010, 80);
`endif

    // round-robin with all requesters held high from reset
    data = 32'h44332211;
    req = 4'b1111;
    rst_pulse("rr_rst");
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      wait_ack();
      check("rr_gid", grant_id, 3'(i % 4));
      if (i > 0) check("rr_pitch", cyc - prev, FLEN + 1);
      prev = cyc;
    end
    req = '0;

    // request raised while busy is deferred to the first idle cycle
    @(negedge clk);
    rst_pulse("busy_rst");
    data[7:0] = 8'h3C;
    req = 4'b0001;
    wait_ack();
    check("busy_gid0", grant_id, 3'd0);
    prev = cyc;
    req = '0;
    repeat (20) @(negedge clk);
    data[23:16] = 8'h81;
    req = 4'b0100;
    seen = 0;
    n = 0;
    while (busy && n < 200) begin
      if (ack != '0) seen = 1;
      @(negedge clk);
      n++;
    end
    check("no_ack_while_busy", seen, 0);
    check("idle_gap_ack", ack, '0);
    wait_ack();
    check("deferred_ack", ack, 4'b0100);
    check("deferred_gid", grant_id, 3'd2);
    check("deferred_pitch", cyc - prev, FLEN + 1);
    req = '0;

    // reset in the middle of data bit 3
    @(negedge clk);
    rst_pulse("pre_rst");
    data[7:0] = 8'h5A;
    req = 4'b0001;
    wait_ack();
    req = '0;
    repeat (35) @(negedge clk);
    check("mid_busy_before", busy, 1'b1);
    rst_pulse("mid_rst");
    @(negedge clk);
    data[31:24] = 8'hE7;
    req = 4'b1001;
    wait_ack();
    check("post_rst_gid_both", grant_id, 3'd0);
    req = '0;
    @(negedge clk);
    rst_pulse("mid_rst2");
    @(negedge clk);
    req = 4'b1000;
    wait_ack();
    check("post_rst_gid_3", grant_id, 3'd3);
    req = '0;

`ifdef ZUART_SCHED_PARITY_EN
    @(negedge clk);
    rst_pulse("par_rst");
    data[7:0] = 8'h07;
    req = 4'b0001;
    wait_ack();
    req = '0;
    frame_check("parity", 11'b11000001110, 88);
`endif
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/zuart_tx_scheduler.md
# zuart_tx_scheduler

Shares one UART transmit line among several requesters in the photon-counter readout path. Arbitrates round-robin between byte requests, captures the winner's byte, and serializes it as an 8N1 frame. Bit timing comes from an internal baud counter that runs only while a frame is in flight, so every frame starts bit-aligned. Sits between the per-channel readout logic and the board's TXD pin.

## Interface
- `NUM_REQ`, 4: number of requesters; legal range 2..8.
- `BPS_DIV`, 434: clock cycles per bit (50 MHz / 115200); legal values are ≥ 2.
- `clk`, input, 1: system clock (50 MHz nominal).
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `req`, input, NUM_REQ: per-requester byte request, level.
- `data`, input, 8*NUM_REQ: byte for requester i is at `[8i+7:8i]`; must be stable while `req[i]` is high and `ack[i]` is low.
- `ack`, output, NUM_REQ: one-cycle pulse when requester i's byte is captured.
- `busy`, output, 1: high whenever the state is not IDLE.
- `grant_id`, output, 3: index of the most recently granted requester.
- `txd`, output, 1: serial output, registered, idle high.

## Operation
- States: IDLE, START, DATA, STOP, and PARITY when compiled in (see Configuration).
- **IDLE**
  - If any `req` bit is high, grant the first requester at or after `rr_ptr`, scanning upward with wrap.
  - At that same edge:
    - pulse `ack[g]`;
    - capture `data[g]` into the shift register;
    - set `grant_id` to g and `rr_ptr` to g+1 (mod NUM_REQ);
    - clear the baud counter;
    - drive `txd` to 0 and go to START.
- **Baud tick:** the counter counts 0..BPS_DIV-1 while not in IDLE. The tick is the cycle where the counter equals BPS_DIV-1, after which it wraps to 0. The counter width is `$clog2(BPS_DIV)`.
- **START:** on tick, drive `txd` to shift[0] and go to DATA with the bit counter at 0.
- **DATA:** on each tick, shift right (LSB first) and increment the bit counter. After bit 7's tick, go to STOP with `txd`=1, or to PARITY if enabled.
- **STOP:** on tick, go to IDLE. `busy` falls the same edge.
- **Repeat requests:** a requester that keeps `req` high after `ack` is treated as a new request. It competes again at the next IDLE, where round-robin prevents starvation.
- **Requests while busy:** `req` changes while busy are ignored until IDLE. Dropping `req` before grant withdraws the request with no side effects.
- **Mid-frame reset:** asserting `rst_n` low aborts the frame. Outputs go to their reset values immediately, with no partial stop bit.

## Timing
- **Reset values:**
  - `txd`=1, `ack`=0, `busy`=0, `grant_id`=0;
  - `rr_ptr`=0, so requester 0 has first priority;
  - state IDLE, counters 0.
- **Grant latency:** `req` sampled high in IDLE at edge k causes `ack` and `busy` to be high and `txd` to be 0 from edge k. `ack` is low again from edge k+1.
- **Bit timing:** each bit lasts exactly BPS_DIV cycles. The frame spans 10·BPS_DIV cycles (11·BPS_DIV with parity), measured from `txd` falling to the STOP state ending.
- **Back-to-back frames:** at least one IDLE cycle separates frames, so the minimum frame pitch is 10·BPS_DIV+1 cycles.
- **Arbitration:** single-cycle and combinational from `req` and `rr_ptr`. All outputs are registered.

## Configuration
- Macro: `ZUART_SCHED_PARITY_EN`.
- **Defined:** a PARITY state is inserted between DATA and STOP.
  - `txd` carries the even parity (XOR of the 8 data bits), computed at capture.
  - The frame is 8E1 and lasts 11·BPS_DIV cycles.
- **Undefined:** no PARITY state and no parity logic. The frame is 8N1 and lasts 10·BPS_DIV cycles.

## Test plan
All scenarios use BPS_DIV=8 and NUM_REQ=4.
- **Single byte:** `req[1]`=1 with byte 0xA5.
  - `ack[1]` is high for one cycle and `grant_id`=1.
  - `txd` carries 0,1,0,1,0,0,1,0,1,1, each bit held 8 cycles.
  - `busy` is high for 80 cycles.
- **Round-robin:** `req`=4'b1111 is held constantly from reset.
  - Grants go 0,1,2,3,0.
  - Successive `ack` pulses are 81 cycles apart.
- **Request while busy:** `req[2]` is raised mid-frame of requester 0.
  - No `ack[2]` appears while busy.
  - `ack[2]` fires on the first IDLE cycle after requester 0's stop bit.
- **Reset mid-frame:** `rst_n` is pulled low during DATA bit 3.
  - `txd`=1, `busy`=0 and `ack`=0 immediately.
  - After release, `req[3]` is granted before requester 0 only if requester 0 is not requesting (`rr_ptr`=0).
- **Parity:** with `ZUART_SCHED_PARITY_EN` defined, send byte 0x07.
  - The parity bit is 1.
  - The frame is 88 cycles, and the stop bit follows the parity bit.
